// File: rtl/tse_rx_frame_buffer_if.sv
// Receive-side bundle: TSE Avalon-ST byte stream in, MAC group byte port out,
// plus drop/occupancy status.
interface tse_rx_frame_buffer_if #(
    parameter int STAT_DEPTH_BITS = 3
);
    logic [7:0]               ff_rx_data;
    logic                     ff_rx_dval;
    logic                     ff_rx_sop;
    logic                     ff_rx_eop;
    logic                     ff_rx_err;
    logic                     ff_rx_rdy;
    logic [7:0]               gmac_rx_data;
    logic                     gmac_rx_dvld;
    logic                     gmac_rx_frame_error;
    logic                     rx_frame_dropped;
    logic [STAT_DEPTH_BITS:0] rx_frames_buffered;

    modport master (
        output ff_rx_data, ff_rx_dval, ff_rx_sop, ff_rx_eop, ff_rx_err,
        input  ff_rx_rdy, gmac_rx_data, gmac_rx_dvld, gmac_rx_frame_error,
        input  rx_frame_dropped, rx_frames_buffered
    );

    modport slave (
        input  ff_rx_data, ff_rx_dval, ff_rx_sop, ff_rx_eop, ff_rx_err,
        output ff_rx_rdy, gmac_rx_data, gmac_rx_dvld, gmac_rx_frame_error,
        output rx_frame_dropped, rx_frames_buffered
    );
endinterface

// File: rtl/tse_rx_frame_buffer.sv
// Store-and-forward rx adapter: buffers whole TSE frames, replays them
// gap-free to the MAC group, drops frames that cannot be held.
module tse_rx_frame_buffer #(
    parameter int ADDR_WIDTH      = 11,
    parameter int STAT_DEPTH_BITS = 3,
    parameter int MAX_FRAME_LEN   = 1522,
    parameter int MIN_IFG         = 12
) (
    input logic clk,
    input logic reset,
    tse_rx_frame_buffer_if.slave bus
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int SDEPTH = 1 << STAT_DEPTH_BITS;
    localparam int SB     = STAT_DEPTH_BITS;
    localparam int LEN_W  = $clog2(MAX_FRAME_LEN + 2);
    localparam int GAP_W  = $clog2(MIN_IFG + 1);

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [LEN_W-1:0]      len_t;
    typedef logic [GAP_W-1:0]      gap_t;
    typedef logic [SB:0]           sptr_t;

    typedef struct packed {
        len_t len;
        logic err;
    } desc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_GAP
    } rd_state_e;

    logic [7:0] mem [DEPTH];
    desc_t      stat_mem [SDEPTH];

    logic      rdy_q;
    logic      in_frame_q, in_frame_d;
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      commit_ptr_q, commit_ptr_d;
    len_t      len_q, len_d;
    logic      bad_q, bad_d;
    logic      drop_q, drop_d;
    sptr_t     stat_wr_q, stat_rd_q;

    rd_state_e state_q, state_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    len_t      cnt_q, cnt_d;
    logic      err_q, err_d;
    gap_t      gap_q, gap_d;
    logic      ferr_q, ferr_d;
    logic [7:0] ram_q;

    logic      accept;
    logic      active;
    logic      we;
    ptr_t      waddr;
    ptr_t      base;
    ptr_t      used;
    ptr_t      raddr;
    logic      push;
    logic      pop;
    logic      stat_full;
    logic      stat_empty;
    desc_t     stat_head;
    desc_t     push_desc;

    assign accept     = bus.ff_rx_dval & rdy_q;
    assign stat_empty = (stat_wr_q == stat_rd_q);
    assign stat_full  = (stat_wr_q[SB] != stat_rd_q[SB]) &&
                        (stat_wr_q[SB-1:0] == stat_rd_q[SB-1:0]);
    assign stat_head  = stat_mem[stat_rd_q[SB-1:0]];
    assign used       = base - rd_ptr_q;

    always_comb begin
        in_frame_d   = in_frame_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        len_d        = len_q;
        bad_d        = bad_q;
        drop_d       = 1'b0;
        push         = 1'b0;
        we           = 1'b0;
        active       = 1'b0;
        base         = wr_ptr_q;
        waddr        = wr_ptr_q;
        push_desc    = '0;
        if (accept) begin
            if (bus.ff_rx_sop) begin
                // a sop inside a frame means the old frame lost its eop
                drop_d = in_frame_q;
                active = 1'b1;
                base   = commit_ptr_q;
                len_d  = '0;
                bad_d  = 1'b0;
            end else begin
                active = in_frame_q;
            end
        end
        if (active) begin
            in_frame_d = 1'b1;
            waddr      = base;
            wr_ptr_d   = base;
            if (used == ptr_t'(DEPTH - 1)) begin
                bad_d = 1'b1;
            end else begin
                we       = 1'b1;
                wr_ptr_d = base + ptr_t'(1);
            end
            if (len_d != '1) len_d = len_d + len_t'(1);
            if (len_d > len_t'(MAX_FRAME_LEN)) bad_d = 1'b1;
            if (bus.ff_rx_eop) begin
                in_frame_d = 1'b0;
                if (!bad_d && !stat_full) begin
                    push          = 1'b1;
                    push_desc.len = len_d;
                    push_desc.err = bus.ff_rx_err;
                    commit_ptr_d  = wr_ptr_d;
                end else begin
                    drop_d   = 1'b1;
                    wr_ptr_d = commit_ptr_q;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        gap_d    = gap_q;
        ferr_d   = ferr_q;
        pop      = 1'b0;
        raddr    = rd_ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (!stat_empty) begin
                    pop     = 1'b1;
                    cnt_d   = stat_head.len;
                    err_d   = stat_head.err;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ferr_d  = err_q;
                state_d = S_SEND;
            end
            S_SEND: begin
                // prefetch one ahead so a byte lands every cycle
                raddr    = rd_ptr_q + ptr_t'(1);
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
                cnt_d    = cnt_q - len_t'(1);
                if (cnt_q == len_t'(1)) begin
                    state_d = S_GAP;
                    gap_d   = gap_t'(MIN_IFG);
                end
            end
            S_GAP: begin
                if (gap_q <= gap_t'(1)) state_d = S_IDLE;
                else gap_d = gap_q - gap_t'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q        <= 1'b0;
            in_frame_q   <= 1'b0;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            bad_q        <= 1'b0;
            drop_q       <= 1'b0;
            stat_wr_q    <= '0;
            stat_rd_q    <= '0;
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            gap_q        <= '0;
            ferr_q       <= 1'b0;
            ram_q        <= '0;
        end else begin
            rdy_q        <= 1'b1;
            in_frame_q   <= in_frame_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            len_q        <= len_d;
            bad_q        <= bad_d;
            drop_q       <= drop_d;
            if (push) stat_wr_q <= stat_wr_q + sptr_t'(1);
            if (pop)  stat_rd_q <= stat_rd_q + sptr_t'(1);
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            gap_q        <= gap_d;
            ferr_q       <= ferr_d;
            ram_q        <= mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= bus.ff_rx_data;
        if (push) stat_mem[stat_wr_q[SB-1:0]] <= push_desc;
    end

    assign bus.ff_rx_rdy           = rdy_q;
    assign bus.gmac_rx_dvld        = (state_q == S_SEND);
    assign bus.gmac_rx_data        = (state_q == S_SEND) ? ram_q : 8'h00;
    assign bus.gmac_rx_frame_error = ferr_q;
    assign bus.rx_frame_dropped    = drop_q;
    assign bus.rx_frames_buffered  = stat_wr_q - stat_rd_q;
endmodule
